glitch_pulser: RTL and testbench

//  Programmable pulse-train generator for the glitcher datapath.
//  On a rising edge of en it waits a programmable delay, then emits N

---
 rtl/glitcher_pkg.sv | 14 +
 rtl/glitch_pulser.sv | 104 ++++++++++
 tb/tb_glitch_pulser.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/glitcher_pkg.sv
// Shared types for the glitcher datapath: sequencer states and config field widths.
package glitcher_pkg;
  localparam int DLY_W = 16;
  localparam int PW_W  = 8;
  localparam int NP_W  = 8;
  localparam int SP_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2,
    SPACE = 2'd3
  } state_t;
endpackage

// File: rtl/glitch_pulser.sv
// Pulse-train generator: after a start, wait delay cycles, then emit N pulses of width W separated by S low cycles.
// Latency: first pulse rises on the edge start+delay; outputs are registered, no backpressure (a start is taken only while ready_o=1).
module glitch_pulser
  import glitcher_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DLY_W-1:0]  delay_i,
  input  logic [PW_W-1:0]   pulse_width_i,
  input  logic [NP_W-1:0]   num_pulses_i,
  input  logic [SP_W-1:0]   pulse_spacing_i,
  output logic              pulse_o,
  output logic              ready_o
);

  state_t            state;
  logic              en_q;
  logic [DLY_W-1:0]  phase_cnt;
  logic [NP_W-1:0]   pulse_cnt;
  logic [PW_W-1:0]   width_m1;
  logic [SP_W-1:0]   space_m1;
  logic [PW_W-1:0]   width_in_m1;
  logic [SP_W-1:0]   space_in_m1;
  logic              start;

  // Zero width/spacing behave as one cycle; store length-1 so the counter ends at zero.
  assign width_in_m1 = (pulse_width_i   == '0) ? '0 : pulse_width_i   - 1'b1;
  assign space_in_m1 = (pulse_spacing_i == '0) ? '0 : pulse_spacing_i - 1'b1;
  assign start       = en && !en_q && ready_o && (num_pulses_i != '0);

  always_ff @(posedge clk) begin
    // Tracking en through reset means a level held across reset is never seen as a rising edge.
    en_q <= en;
    if (rst) begin
      state     <= IDLE;
      pulse_o   <= 1'b0;
      ready_o   <= 1'b1;
      phase_cnt <= '0;
      pulse_cnt <= '0;
      width_m1  <= '0;
      space_m1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ready_o   <= 1'b0;
            width_m1  <= width_in_m1;
            space_m1  <= space_in_m1;
            pulse_cnt <= num_pulses_i;
            if (delay_i == '0) begin
              state     <= PULSE;
              pulse_o   <= 1'b1;
              phase_cnt <= {{(DLY_W-PW_W){1'b0}}, width_in_m1};
            end else begin
              state     <= DELAY;
              phase_cnt <= delay_i - 1'b1;
            end
          end
        end
        DELAY: begin
          if (phase_cnt == '0) begin
            state     <= PULSE;
            pulse_o   <= 1'b1;
            phase_cnt <= {{(DLY_W-PW_W){1'b0}}, width_m1};
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        PULSE: begin
          if (phase_cnt == '0) begin
            pulse_o <= 1'b0;
            if (pulse_cnt == NP_W'(1)) begin
              state     <= IDLE;
              ready_o   <= 1'b1;
              pulse_cnt <= '0;
            end else begin
              state     <= SPACE;
              pulse_cnt <= pulse_cnt - 1'b1;
              phase_cnt <= space_m1;
            end
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        SPACE: begin
          if (phase_cnt == '0) begin
            state     <= PULSE;
            pulse_o   <= 1'b1;
            phase_cnt <= {{(DLY_W-PW_W){1'b0}}, width_m1};
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          pulse_o <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_pulser.sv
// Bench for glitch_pulser: per-cycle expected outputs from an arithmetic timing model, checked by a scoreboard monitor.
module tb_glitch_pulser;
  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] delay_i;
  logic [7:0]  pulse_width_i;
  logic [7:0]  num_pulses_i;
  logic [15:0] pulse_spacing_i;
  logic        pulse_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;
  bit [1:0] exp_q[$];

  glitch_pulser dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .delay_i         (delay_i),
    .pulse_width_i   (pulse_width_i),
    .num_pulses_i    (num_pulses_i),
    .pulse_spacing_i (pulse_spacing_i),
    .pulse_o         (pulse_o),
    .ready_o         (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a sequence is a start time plus four numbers; outputs follow from arithmetic on the cycle index.
  int cyc = 0;
  bit en_prev = 1'b0;
  bit rdy_prev = 1'b1;
  bit act = 1'b0;
  int t0, md, mw, ms, mn, t_end;

  always @(posedge clk) begin
    bit exp_pulse, exp_ready;
    int rel, period;
    cyc++;
    exp_pulse = 1'b0;
    exp_ready = 1'b1;
    if (rst) begin
      act = 1'b0;
    end else begin
      if (en && !en_prev && rdy_prev && num_pulses_i != 0) begin
        act = 1'b1;
        t0  = cyc;
        md  = int'(delay_i);
        mw  = (pulse_width_i == 0) ? 1 : int'(pulse_width_i);
        ms  = (pulse_spacing_i == 0) ? 1 : int'(pulse_spacing_i);
        mn  = int'(num_pulses_i);
        t_end = t0 + md + mn * mw + (mn - 1) * ms;
      end
      if (act && cyc < t_end) begin
        exp_ready = 1'b0;
        period = mw + ms;
        rel = cyc - t0 - md;
        if (rel >= 0 && rel < mn * period - ms && (rel % period) < mw)
          exp_pulse = 1'b1;
      end
    end
    en_prev  = en;
    rdy_prev = exp_ready;
    exp_q.push_back({exp_pulse, exp_ready});
  end

  always @(negedge clk) begin
    bit [1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({pulse_o, ready_o} !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d pulse_o/ready_o got %b%b expected %b%b",
                 cyc, pulse_o, ready_o, e[1], e[0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int d, input int w, input int n, input int s);
    delay_i         = 16'(d);
    pulse_width_i   = 8'(w);
    num_pulses_i    = 8'(n);
    pulse_spacing_i = 16'(s);
  endtask

  function automatic int seq_len(input int d, input int w, input int n, input int s);
    int ww, ss;
    ww = (w == 0) ? 1 : w;
    ss = (s == 0) ? 1 : s;
    return d + n * (ww + ss) + 4;
  endfunction

  task automatic run_seq(input int d, input int w, input int n, input int s);
    en = 1'b0;
    tick(1);
    set_cfg(d, w, n, s);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(seq_len(d, w, n, s));
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    set_cfg(2, 2, 2, 2);
    tick(3);
    // en held high across reset release must not start anything
    rst = 1'b0;
    tick(10);

    run_seq(10, 3, 1, 7);
    run_seq(0, 2, 3, 4);
    run_seq(1, 0, 2, 0);
    run_seq(3, 4, 0, 2);

    // Restart attempt mid-run and config churn must not disturb the train
    en = 1'b0;
    tick(1);
    set_cfg(0, 2, 3, 4);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    set_cfg(9, 1, 7, 1);
    tick(3);
    en = 1'b1;
    tick(2);
    en = 1'b0;
    set_cfg(0, 0, 0, 0);
    tick(15);

    // Reset during a pulse, then a full fresh train
    en = 1'b0;
    tick(1);
    set_cfg(2, 5, 2, 3);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    run_seq(2, 5, 2, 3);

    // Earliest restart: en high on the first ready cycle
    en = 1'b0;
    tick(1);
    set_cfg(1, 2, 2, 1);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(6);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(10);

    run_seq(1500, 255, 3, 700);
    run_seq(0, 1, 40, 1);

    for (int it = 0; it < 60; it++) begin
      int d, w, n, s, len, rst_at;
      d = $urandom_range(0, 20);
      w = $urandom_range(0, 6);
      n = $urandom_range(0, 5);
      s = $urandom_range(0, 6);
      len = seq_len(d, w, n, s);
      rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len) : -1;
      en = 1'b0;
      tick(1);
      set_cfg(d, w, n, s);
      en = 1'b1;
      tick(1);
      for (int c = 0; c < len; c++) begin
        en  = ($urandom_range(0, 3) == 0);
        rst = (c == rst_at);
        if ($urandom_range(0, 4) == 0)
          set_cfg($urandom_range(0, 20), $urandom_range(0, 6),
                  $urandom_range(0, 5), $urandom_range(0, 6));
        tick(1);
      end
      rst = 1'b0;
    end

    en = 1'b0;
    tick(60);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain pending got %0d expected at most 1", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
